bit_count_arbiter: RTL

- Round-robin scheduler that shares one bit_count datapath (start/data/result/done ASMD) among N requesters.
- Selects a requester, latches its data, and drives the datapath start line through the full start/done/release handshake.
- Returns the result to the winner with a one-cycle ack.
- Watchdog aborts a service that never completes.
- Sits between the client logic and the single bit_count instance on the DE1_SoC top level.

---
 rtl/bit_count_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bit_count_arbiter.sv
// Round-robin front end that time-shares a single bit_count datapath among N requesters.
// Drives the start/done/release handshake, returns the count with a one-cycle ack, and aborts stalled services.
module bit_count_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int RW      = 4,
  parameter int TIMEOUT = 32,
  localparam int IW     = (N > 1) ? $clog2(N) : 1,
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data_in,
  output logic [N-1:0]    ack,
  output logic [RW-1:0]   result,
  output logic            err,
  output logic            busy,
  output logic [IW-1:0]   gnt_idx,
  output logic            bc_s,
  output logic [W-1:0]    bc_data,
  input  logic [RW-1:0]   bc_result,
  input  logic            bc_done
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          err_q, err_d;
  logic [RW-1:0] result_q, result_d;
  logic          bc_s_q, bc_s_d;
  logic [W-1:0]  bc_data_q, bc_data_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic          busy_q, busy_d;

  logic          win_found;
  logic [IW-1:0] win_idx;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin : rr_pick
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    err_d     = 1'b0;
    result_d  = result_q;
    bc_s_d    = bc_s_q;
    bc_data_d = bc_data_q;
    wdog_d    = wdog_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d     = win_idx;
          bc_data_d = data_in[win_idx*W +: W];
          wdog_d    = '0;
          bc_s_d    = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bc_done) begin
          result_d = bc_result;
          ack_d    = {{(N-1){1'b0}}, 1'b1} << gnt_q;
          bc_s_d   = 1'b0;
          state_d  = S_RELEASE;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          result_d = '0;
          ack_d    = {{(N-1){1'b0}}, 1'b1} << gnt_q;
          err_d    = 1'b1;
          bc_s_d   = 1'b0;
          state_d  = S_RELEASE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RELEASE: begin
        // Hold here until the datapath has dropped done, so it is idle before the next start.
        if (!bc_done) begin
          ptr_d   = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      bc_s_q    <= 1'b0;
      bc_data_q <= '0;
      wdog_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      result_q  <= result_d;
      bc_s_q    <= bc_s_d;
      bc_data_q <= bc_data_d;
      wdog_q    <= wdog_d;
      busy_q    <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign err     = err_q;
  assign result  = result_q;
  assign busy    = busy_q;
  assign gnt_idx = gnt_q;
  assign bc_s    = bc_s_q;
  assign bc_data = bc_data_q;

endmodule
